// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, word type and address-width helper for the register file
package regfile_pkg;
  localparam int XLEN_DEF = 64;
  localparam int NREGS_DEF = 32;
  typedef logic [XLEN_DEF-1:0] xword_t;
  function automatic int addrWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bus of the scoreboarded register file
interface regfile_sb_if import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  parameter int NWR = 2,
  localparam int AW = addrWidth(NREGS)
);
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0] rd_ready;
  logic iss_valid;
  logic [AW-1:0] iss_rd;
  logic iss_ready;
  logic [NWR-1:0] wb_valid;
  logic [NWR*AW-1:0] wb_addr;
  logic [NWR*XLEN-1:0] wb_data;
  logic flush;
  logic [AW:0] busy_cnt;
  modport master (
    output rd_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data, flush,
    input rd_data, rd_ready, iss_ready, busy_cnt
  );
  modport slave (
    input rd_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data, flush,
    output rd_data, rd_ready, iss_ready, busy_cnt
  );
endinterface

// File: rtl/regfile_bypass.sv
// regfile_bypass: per-read-port writeback forwarding with highest-port priority
module regfile_bypass #(
  parameter int XLEN = 64,
  parameter int NWR = 2,
  parameter int AW = 5,
  parameter bit BYPASS = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [AW-1:0] addr,
  input  logic [XLEN-1:0] stored,
  input  logic [NWR-1:0] wbValid,
  input  logic [NWR*AW-1:0] wbAddr,
  input  logic [NWR*XLEN-1:0] wbData,
  output logic [XLEN-1:0] data,
  output logic hit
);
  logic isZero;
  assign isZero = ZERO_REG && addr == '0;
  // Scan ports upward so the highest matching writeback port ends up selected
  always_comb begin
    hit = 1'b0;
    data = isZero ? '0 : stored;
    for (int j = 0; j < NWR; j++)
      if (BYPASS && !isZero && wbValid[j] && wbAddr[j*AW +: AW] == addr) begin
        hit = 1'b1;
        data = wbData[j*XLEN +: XLEN];
      end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with busy scoreboard and writeback bypass
module regfile_sb import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter bit BYPASS = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW = addrWidth(NREGS)
) (
  input logic clk,
  input logic rst_n,
  regfile_sb_if.slave bus
);
  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] busy, busyNext;
  logic [AW:0] busyCnt, cntNext;
  logic issZero, issFire;
  assign issZero = ZERO_REG && bus.iss_rd == '0;
  assign bus.iss_ready = !bus.flush && (!busy[bus.iss_rd] || issZero);
  assign issFire = bus.iss_valid && bus.iss_ready && !issZero;
  assign bus.busy_cnt = busyCnt;
  // Storage: later write ports override earlier ones on a shared address; r0 writes dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    else for (int j = 0; j < NWR; j++)
      if (bus.wb_valid[j] && !(ZERO_REG && bus.wb_addr[j*AW +: AW] == '0))
        mem[bus.wb_addr[j*AW +: AW]] <= bus.wb_data[j*XLEN +: XLEN];
  // Next busy vector: flush or writeback clears, a new issue sets and beats a same-cycle clear
  always_comb begin
    busyNext = bus.flush ? '0 : busy;
    for (int j = 0; j < NWR; j++)
      if (bus.wb_valid[j]) busyNext[bus.wb_addr[j*AW +: AW]] = 1'b0;
    if (issFire) busyNext[bus.iss_rd] = 1'b1;
    cntNext = '0;
    for (int r = 0; r < NREGS; r++) cntNext = cntNext + (AW+1)'(busyNext[r]);
  end
  // Scoreboard state and its registered population count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= '0;
      busyCnt <= '0;
    end else begin
      busy <= busyNext;
      busyCnt <= cntNext;
    end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic [XLEN-1:0] d;
    logic hit;
    assign a = bus.rd_addr[i*AW +: AW];
    regfile_bypass #(
      .XLEN(XLEN), .NWR(NWR), .AW(AW), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_byp (
      .addr(a), .stored(mem[a]), .wbValid(bus.wb_valid), .wbAddr(bus.wb_addr),
      .wbData(bus.wb_data), .data(d), .hit(hit)
    );
    assign bus.rd_data[i*XLEN +: XLEN] = d;
    assign bus.rd_ready[i] = !busy[a] || hit || (ZERO_REG && a == '0);
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed plus randomized checks of regfile_sb against an array-based model
module tb_regfile_sb;
  import regfile_pkg::*;
  localparam int XLEN = 64;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  xword_t regsM [NREGS];
  bit busyM [NREGS];
  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();
  regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1), .ZERO_REG(1'b1)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic int busyCount();
    int n = 0;
    for (int r = 0; r < NREGS; r++) n += int'(busyM[r]);
    return n;
  endfunction
  function automatic bit expIssReady();
    int a = int'(bus.iss_rd);
    return !bus.flush && (a == 0 || !busyM[a]);
  endfunction
  function automatic void expRead(input int p, output xword_t d, output bit rdy);
    int a = int'(bus.rd_addr[p*AW +: AW]);
    d = regsM[a];
    rdy = !busyM[a];
    if (a == 0) begin
      d = '0;
      rdy = 1'b1;
      return;
    end
    for (int j = NWR - 1; j >= 0; j--)
      if (bus.wb_valid[j] && int'(bus.wb_addr[j*AW +: AW]) == a) begin
        d = bus.wb_data[j*XLEN +: XLEN];
        rdy = 1'b1;
        break;
      end
  endfunction
  function automatic void modelReset();
    for (int r = 0; r < NREGS; r++) begin
      regsM[r] = '0;
      busyM[r] = 1'b0;
    end
  endfunction
  task automatic idle();
    bus.rd_addr = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd = '0;
    bus.wb_valid = '0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    bus.flush = 1'b0;
  endtask
  task automatic sample();
    xword_t d;
    bit r;
    @(negedge clk);
    for (int p = 0; p < NRD; p++) begin
      expRead(p, d, r);
      check($sformatf("rd_data%0d", p), bus.rd_data[p*XLEN +: XLEN], d);
      check($sformatf("rd_ready%0d", p), 64'(bus.rd_ready[p]), 64'(r));
    end
    check("iss_ready", 64'(bus.iss_ready), 64'(expIssReady()));
    check("busy_cnt", 64'(bus.busy_cnt), 64'(busyCount()));
  endtask
  task automatic tick();
    bit ir = expIssReady();
    @(posedge clk);
    for (int j = 0; j < NWR; j++)
      if (bus.wb_valid[j] && bus.wb_addr[j*AW +: AW] != '0)
        regsM[int'(bus.wb_addr[j*AW +: AW])] = bus.wb_data[j*XLEN +: XLEN];
    if (bus.flush) for (int r = 0; r < NREGS; r++) busyM[r] = 1'b0;
    else for (int j = 0; j < NWR; j++)
      if (bus.wb_valid[j]) busyM[int'(bus.wb_addr[j*AW +: AW])] = 1'b0;
    if (bus.iss_valid && ir && bus.iss_rd != '0) busyM[int'(bus.iss_rd)] = 1'b1;
    #1;
  endtask
  task automatic issue(input int r);
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_rd = AW'(r);
  endtask
  function automatic logic [AW-1:0] rndAddr();
    return ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
  endfunction
  initial begin
    rst_n = 1'b0;
    idle();
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int a = 0; a < NREGS; a++) begin
      bus.rd_addr = {AW'(NREGS - 1 - a), AW'(a)};
      sample();
      check("rst_data", bus.rd_data, '0);
      check("rst_ready", 64'(bus.rd_ready), 64'(2'b11));
      tick();
    end
    check("rst_cnt", 64'(bus.busy_cnt), 0);
    issue(5);
    sample();
    check("iss5", 64'(bus.iss_ready), 1);
    tick();
    idle();
    bus.rd_addr[AW-1:0] = 5'd5;
    sample();
    check("busy5_ready", 64'(bus.rd_ready[0]), 0);
    check("busy5_cnt", 64'(bus.busy_cnt), 1);
    tick();
    bus.wb_valid = 2'b01;
    bus.wb_addr[AW-1:0] = 5'd5;
    bus.wb_data[XLEN-1:0] = 64'hDEAD;
    sample();
    check("byp5_data", bus.rd_data[XLEN-1:0], 64'hDEAD);
    check("byp5_ready", 64'(bus.rd_ready[0]), 1);
    tick();
    idle();
    bus.rd_addr[AW-1:0] = 5'd5;
    sample();
    check("st5_data", bus.rd_data[XLEN-1:0], 64'hDEAD);
    check("st5_cnt", 64'(bus.busy_cnt), 0);
    tick();
    issue(7);
    sample();
    check("iss7a", 64'(bus.iss_ready), 1);
    tick();
    issue(7);
    sample();
    check("iss7b", 64'(bus.iss_ready), 0);
    tick();
    issue(7);
    bus.wb_valid = 2'b10;
    bus.wb_addr[2*AW-1:AW] = 5'd7;
    bus.wb_data[2*XLEN-1:XLEN] = 64'h77;
    sample();
    check("iss7_waw", 64'(bus.iss_ready), 0);
    tick();
    issue(7);
    sample();
    check("iss7c", 64'(bus.iss_ready), 1);
    tick();
    idle();
    bus.wb_valid = 2'b01;
    bus.wb_addr[AW-1:0] = 5'd7;
    sample();
    tick();
    idle();
    bus.wb_valid = 2'b11;
    bus.wb_addr = {5'd9, 5'd9};
    bus.wb_data = {64'h2, 64'h1};
    bus.rd_addr[AW-1:0] = 5'd9;
    sample();
    check("dual9_byp", bus.rd_data[XLEN-1:0], 64'h2);
    tick();
    idle();
    bus.rd_addr[AW-1:0] = 5'd9;
    sample();
    check("dual9_st", bus.rd_data[XLEN-1:0], 64'h2);
    tick();
    issue(0);
    sample();
    check("iss0", 64'(bus.iss_ready), 1);
    tick();
    idle();
    bus.wb_valid = 2'b01;
    bus.wb_data[XLEN-1:0] = 64'hFF;
    sample();
    check("r0_cnt", 64'(bus.busy_cnt), 0);
    check("r0_byp", bus.rd_data[XLEN-1:0], 0);
    tick();
    idle();
    sample();
    check("r0_st", bus.rd_data[XLEN-1:0], 0);
    tick();
    issue(3); sample(); tick();
    issue(4); sample(); tick();
    issue(6); sample(); tick();
    idle();
    sample();
    check("cnt3", 64'(bus.busy_cnt), 3);
    tick();
    issue(8);
    bus.flush = 1'b1;
    sample();
    check("flush_iss", 64'(bus.iss_ready), 0);
    tick();
    idle();
    sample();
    check("flush_cnt", 64'(bus.busy_cnt), 0);
    tick();
    issue(10);
    bus.rd_addr[AW-1:0] = 5'd5;
    sample();
    check("pre_rst", bus.rd_data[XLEN-1:0], 64'hDEAD);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data", bus.rd_data[XLEN-1:0], 0);
    check("async_rst_cnt", 64'(bus.busy_cnt), 0);
    modelReset();
    idle();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (600) begin
      for (int p = 0; p < NRD; p++) bus.rd_addr[p*AW +: AW] = rndAddr();
      bus.iss_valid = ($urandom_range(0, 1) == 1);
      bus.iss_rd = rndAddr();
      for (int j = 0; j < NWR; j++) begin
        bus.wb_valid[j] = ($urandom_range(0, 2) == 0);
        bus.wb_addr[j*AW +: AW] = rndAddr();
        bus.wb_data[j*XLEN +: XLEN] = {$urandom, $urandom};
      end
      bus.flush = ($urandom_range(0, 19) == 0);
      sample();
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
